// File: rtl/rssi_agc_pkg.sv
`default_nettype none
// ============================================================================
//  Module : rssi_agc_pkg
//  Purpose: Shared definitions for the RSSI gain controller. Holds the FSM
//           state encoding, the debug state-code width and the helpers that
//           derive the hysteresis exit thresholds used while locked.
//  Ports  : none (package)
//  Rev    : 1.0  initial release
// ============================================================================
package rssi_agc_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_ADJUST  = 3'd3,
    ST_LOCKED  = 3'd4
  } state_t;

  // Lower exit threshold, clamped at 0. The 9-bit difference keeps the
  // borrow visible so a large hysteresis cannot wrap to a high threshold.
  function automatic logic [7:0] exit_lo(input logic [7:0] tgt_lo,
                                         input logic [7:0] hyst);
    logic [8:0] diff;
    diff = {1'b0, tgt_lo} - {1'b0, hyst};
    return diff[8] ? 8'd0 : diff[7:0];
  endfunction

  // Upper exit threshold, clamped at 255 via the 9-bit carry.
  function automatic logic [7:0] exit_hi(input logic [7:0] tgt_hi,
                                         input logic [7:0] hyst);
    logic [8:0] sum;
    sum = {1'b0, tgt_hi} + {1'b0, hyst};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rssi_rdy_watchdog.sv
`default_nettype none
// ============================================================================
//  Module : rssi_rdy_watchdog
//  Purpose: Loss-of-signal timer. Reloads on every estimate strobe and while
//           not running; counts down while running and emits a one-cycle
//           expire pulse on the TIMEOUT-th clock without a strobe.
//  Ports  : clk    - system clock
//           rst_n  - asynchronous active-low reset
//           clear  - estimate strobe seen; reload (wins over expiry)
//           run    - controller is in a watched state
//           expire - one-cycle timeout pulse (combinational from counter)
//  Rev    : 1.0  initial release
// ============================================================================
module rssi_rdy_watchdog #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // cnt==1 means this edge completes TIMEOUT clocks since the last reload.
  assign expire = run && !clear && (cnt == LAST);

  // Reloading on expiry lets the controller keep re-arming while the signal
  // stays absent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
    end else if (clear || !run || expire) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - LAST;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rssi_agc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : rssi_agc_ctrl
//  Purpose: Closed-loop front-end gain controller. Steps the gain code one
//           LSB per averaged RSSI estimate until the estimate lies inside
//           [TGT_LO,TGT_HI], locks after LOCK_CNT in-window estimates and
//           holds with hysteresis. Discards SETTLE_CNT estimates after each
//           gain change; a watchdog forces full gain on loss of signal.
//  Ports  : clk, rst_n        - clock, asynchronous active-low reset
//           enable            - level enable; low forces IDLE
//           rssi, rssi_rdy    - averaged RSSI and its one-cycle strobe
//           gain, gain_upd    - registered gain code, pulse on change
//           locked            - loop locked
//           sat_lo, sat_hi    - gain pinned at a rail, RSSI still outside
//           no_sig            - watchdog expired, clears on next strobe
//           state_o           - current state code (debug)
//  Rev    : 1.0  initial release
// ============================================================================
module rssi_agc_ctrl
  import rssi_agc_pkg::*;
#(
  parameter int         GAIN_W     = 4,
  parameter int         GAIN_INIT  = 8,
  parameter int         GAIN_MAX   = 15,
  parameter logic [7:0] TGT_LO     = 8'd96,
  parameter logic [7:0] TGT_HI     = 8'd160,
  parameter logic [7:0] HYST       = 8'd16,
  parameter int         SETTLE_CNT = 64,
  parameter int         LOCK_CNT   = 4,
  parameter int         TIMEOUT    = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [7:0]         rssi,
  input  logic               rssi_rdy,
  output logic [GAIN_W-1:0]  gain,
  output logic               gain_upd,
  output logic               locked,
  output logic               sat_lo,
  output logic               sat_hi,
  output logic               no_sig,
  output logic [STATE_W-1:0] state_o
);

  localparam int SC_W = $clog2(SETTLE_CNT + 1);
  localparam int LC_W = $clog2(LOCK_CNT + 1);

  localparam logic [GAIN_W-1:0] G_INIT  = GAIN_W'(GAIN_INIT);
  localparam logic [GAIN_W-1:0] G_MAX   = GAIN_W'(GAIN_MAX);
  localparam logic [GAIN_W-1:0] G_ONE   = GAIN_W'(1);
  localparam logic [GAIN_W-1:0] G_ZERO  = '0;
  localparam logic [SC_W-1:0]   SC_LAST = SC_W'(SETTLE_CNT - 1);
  localparam logic [SC_W-1:0]   SC_ONE  = SC_W'(1);
  localparam logic [LC_W-1:0]   LC_LAST = LC_W'(LOCK_CNT - 1);
  localparam logic [LC_W-1:0]   LC_ONE  = LC_W'(1);
  localparam logic [7:0]        LO_X    = exit_lo(TGT_LO, HYST);
  localparam logic [7:0]        HI_X    = exit_hi(TGT_HI, HYST);

  state_t            state, state_nxt;
  logic [GAIN_W-1:0] gain_nxt;
  logic              gain_upd_nxt, locked_nxt, sat_lo_nxt, sat_hi_nxt, no_sig_nxt;
  logic [SC_W-1:0]   settle_cnt, settle_cnt_nxt;
  logic [LC_W-1:0]   lock_cnt, lock_cnt_nxt;
  logic              wd_run, wd_expire;

  assign wd_run = enable && ((state == ST_SETTLE) || (state == ST_MEASURE) ||
                             (state == ST_LOCKED));

  rssi_rdy_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rssi_rdy),
    .run    (wd_run),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gain       <= G_INIT;
      gain_upd   <= 1'b0;
      locked     <= 1'b0;
      sat_lo     <= 1'b0;
      sat_hi     <= 1'b0;
      no_sig     <= 1'b0;
      settle_cnt <= '0;
      lock_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      gain       <= gain_nxt;
      gain_upd   <= gain_upd_nxt;
      locked     <= locked_nxt;
      sat_lo     <= sat_lo_nxt;
      sat_hi     <= sat_hi_nxt;
      no_sig     <= no_sig_nxt;
      settle_cnt <= settle_cnt_nxt;
      lock_cnt   <= lock_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    gain_nxt       = gain;
    locked_nxt     = locked;
    sat_lo_nxt     = sat_lo;
    sat_hi_nxt     = sat_hi;
    no_sig_nxt     = no_sig;
    settle_cnt_nxt = settle_cnt;
    lock_cnt_nxt   = lock_cnt;

    if (!enable) begin
      // Disable overrides every other event on this edge.
      state_nxt      = ST_IDLE;
      gain_nxt       = G_INIT;
      locked_nxt     = 1'b0;
      sat_lo_nxt     = 1'b0;
      sat_hi_nxt     = 1'b0;
      no_sig_nxt     = 1'b0;
      settle_cnt_nxt = '0;
      lock_cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt      = ST_SETTLE;
          settle_cnt_nxt = '0;
        end

        ST_ADJUST: begin
          // A strobe arriving here is dropped: the estimate predates the step.
          state_nxt      = ST_SETTLE;
          settle_cnt_nxt = '0;
          lock_cnt_nxt   = '0;
          sat_lo_nxt     = 1'b0;
          sat_hi_nxt     = 1'b0;
        end

        ST_SETTLE, ST_MEASURE, ST_LOCKED: begin
          if (rssi_rdy) begin
            no_sig_nxt = 1'b0;
            if (state == ST_SETTLE) begin
              settle_cnt_nxt = settle_cnt + SC_ONE;
              if (settle_cnt == SC_LAST) begin
                state_nxt    = ST_MEASURE;
                lock_cnt_nxt = '0;
              end
            end else if ((state == ST_MEASURE && rssi < TGT_LO) ||
                         (state == ST_LOCKED  && rssi < LO_X)) begin
              locked_nxt = 1'b0;
              if (gain < G_MAX) begin
                gain_nxt  = gain + G_ONE;
                state_nxt = ST_ADJUST;
              end else begin
                sat_lo_nxt   = 1'b1;
                lock_cnt_nxt = '0;
                state_nxt    = ST_MEASURE;
              end
            end else if ((state == ST_MEASURE && rssi > TGT_HI) ||
                         (state == ST_LOCKED  && rssi > HI_X)) begin
              locked_nxt = 1'b0;
              if (gain > G_ZERO) begin
                gain_nxt  = gain - G_ONE;
                state_nxt = ST_ADJUST;
              end else begin
                sat_hi_nxt   = 1'b1;
                lock_cnt_nxt = '0;
                state_nxt    = ST_MEASURE;
              end
            end else if (state == ST_MEASURE) begin
              sat_lo_nxt   = 1'b0;
              sat_hi_nxt   = 1'b0;
              lock_cnt_nxt = lock_cnt + LC_ONE;
              if (lock_cnt == LC_LAST) begin
                state_nxt  = ST_LOCKED;
                locked_nxt = 1'b1;
              end
            end
            // Locked and inside the hysteresis band: hold everything.
          end else if (wd_expire) begin
            // Lost signal: open the front end fully and keep re-settling.
            no_sig_nxt     = 1'b1;
            locked_nxt     = 1'b0;
            gain_nxt       = G_MAX;
            state_nxt      = ST_SETTLE;
            settle_cnt_nxt = '0;
            lock_cnt_nxt   = '0;
          end
        end

        default: begin
          state_nxt = ST_IDLE;
          gain_nxt  = G_INIT;
        end
      endcase
    end

    // Pulse exactly on the first cycle the register shows a new code.
    gain_upd_nxt = (gain_nxt != gain);
  end

  assign state_o = state;

endmodule
`default_nettype wire
